hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Combines three event sources into per-stage register enables and squash controls:
  - the load-use hazard flag from the forwarding logic;
  - split I-cache/D-cache miss handshakes;
  - EX-stage taken-branch/jump.
- Latches a cache response that arrives while the other cache still stalls, so no fetched instruction or load data is lost.
- Keeps saturating performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall_lw  in  1  load-use hazard detected for the instruction in ID
- br_taken  in  1  EX-stage branch/jump redirects the PC this cycle
- icache_read  in  1  IF fetch request
- icache_resp  in  1  I-cache data valid (single-cycle pulse)
- dcache_read  in  1  MEM load request
- dcache_write  in  1  MEM store request
- dcache_resp  in  1  D-cache done (single-cycle pulse)
- cnt_clear  in  1  synchronous clear of all counters
- load_pc, load_ifid, load_idex, load_exmem, load_memwb  out  1 each  stage register enables
- flush_ifid  out  1  IF/ID loads a NOP
- bubble_idex  out  1  ID/EX loads a NOP control word
- ibuf_load  out  1  capture I-cache rdata into the fetch holding register
- ibuf_sel  out  1  IF/ID takes the instruction from the holding register
- dbuf_load  out  1  capture D-cache rdata into the load holding register
- dbuf_sel  out  1  MEM/WB takes load data from the holding register
- icache_mask  out  1  gate icache_read off (already satisfied)
- dcache_mask  out  1  gate dcache_read/write off (already satisfied)
- stall_cycles  out  CNT_W  cycles with the pipe frozen by memory
- bubble_count  out  CNT_W  load-use bubbles inserted
- flush_count  out  CNT_W  redirect flushes

Behaviour:
- State is two flags, i_done and d_done, plus the three counters. All other outputs are combinational from flags and inputs.
- Reset:
  - i_done = d_done = 0 and all counters = 0.
  - While rst = 1, every output except the counters is 0.
- Derived terms:
  - i_ok = ~icache_read | icache_resp | i_done
  - d_ok = ~(dcache_read | dcache_write) | dcache_resp | d_done
  - advance = i_ok & d_ok
- Response latching:
  - ibuf_load = icache_resp & ~i_done & ~advance.
  - i_done next state:
    - cleared on advance;
    - set on ibuf_load;
    - otherwise held.
  - ibuf_sel = icache_mask = i_done.
  - D side is symmetric: dbuf_load, d_done, dbuf_sel, dcache_mask.
- advance = 0 (memory freeze):
  - all load_* = 0, flush_ifid = 0, bubble_idex = 0;
  - stall_cycles increments;
  - br_taken and stall_lw are ignored, because the frozen EX/ID re-present them later.
- advance = 1 and br_taken = 1:
  - all load_* = 1, flush_ifid = 1, bubble_idex = 1;
  - flush_count increments;
  - br_taken has priority over stall_lw, since the ID instruction is on the wrong path.
- advance = 1, br_taken = 0, stall_lw = 1:
  - load_pc = load_ifid = 0;
  - load_idex = load_exmem = load_memwb = 1;
  - bubble_idex = 1, flush_ifid = 0;
  - bubble_count increments once per stalled cycle.
  - The held front end refetches; a latched instruction is dropped because i_done clears.
- advance = 1, no events: all load_* = 1, flush and bubble outputs 0.
- Responses on the same cycle as advance are used directly; nothing is latched and flags stay 0.
- Counters:
  - saturate at 2^CNT_W−1 (no wrap);
  - cnt_clear beats a same-cycle increment (result 0);
  - rst beats cnt_clear.
- A cache_resp arriving while its flag is already set is a protocol error. The flag holds and no second capture occurs.

Decomposition:
- Add a stall-cause enum to rv32i_types for debug/trace, with values STALL_NONE, STALL_MEM, STALL_LOADUSE and STALL_FLUSH.
- One sub-module, sat_counter (parameter CNT_W; inputs clk, rst, clr, inc; output count), instantiated three times.

Test Plan:
- I-miss only: icache_read held, icache_resp at cycle 4 → load_* = 0 for cycles 0–3, all 1 at cycle 4, stall_cycles = 4, ibuf_load never 1.
- Split responses: I-miss and D-load issued together, icache_resp at cycle 2, dcache_resp at cycle 6 → ibuf_load = 1 at cycle 2; icache_mask/ibuf_sel = 1 for cycles 3–6; advance at cycle 6 with ibuf_sel = 1; i_done = 0 at cycle 7; stall_cycles = 6.
- Load-use: stall_lw = 1 for 2 cycles, no misses → load_pc = load_ifid = 0 and bubble_idex = 1 both cycles, back-end enables 1, bubble_count = 2.
- Branch plus load-use in the same cycle → flush_ifid = bubble_idex = 1, all load_* = 1, flush_count += 1, bubble_count unchanged.
- Branch during a D-miss: br_taken held 3 cycles while dcache busy, resp at cycle 3 → no flush until cycle 3, exactly one flush_count increment.
- Counter edges:
  - preload stall_cycles to all-ones, then stall → value holds at all-ones;
  - cnt_clear with a simultaneous stall → 0;
  - rst mid-stall with i_done = 1 → flag and counters 0 on the next cycle.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared pipeline types. The stall-cause enum labels why the pipe did not
// advance normally this cycle. It is used for debug/trace.
package rv32i_types;

    typedef enum logic [1:0] {
        STALL_NONE    = 2'd0,
        STALL_MEM     = 2'd1,
        STALL_LOADUSE = 2'd2,
        STALL_FLUSH   = 2'd3
    } stall_cause_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear. Reset has priority over
// clear, and clear has priority over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Count up on inc and stop at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. It merges these events:
// - memory-miss freezes
// - EX redirects
// - load-use bubbles
// From them it produces the stage enables and squash controls.
// When one cache answers while the other is still busy, that response is
// latched into a holding register. Nothing is lost across the freeze.
module hazard_controller
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_lw,
    input  logic             br_taken,
    input  logic             icache_read,
    input  logic             icache_resp,
    input  logic             dcache_read,
    input  logic             dcache_write,
    input  logic             dcache_resp,
    input  logic             cnt_clear,
    output logic             load_pc,
    output logic             load_ifid,
    output logic             load_idex,
    output logic             load_exmem,
    output logic             load_memwb,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic             ibuf_load,
    output logic             ibuf_sel,
    output logic             dbuf_load,
    output logic             dbuf_sel,
    output logic             icache_mask,
    output logic             dcache_mask,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
);

    logic         i_done_reg, i_done_next;
    logic         d_done_reg, d_done_next;
    logic         i_ok, d_ok, advance;
    stall_cause_t cause;
    logic         cnt_inc   [3];
    logic [CNT_W-1:0] cnt_val [3];

    // Completion flags; a set flag means the response is parked in a holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_done_reg <= 1'b0;
            d_done_reg <= 1'b0;
        end else begin
            i_done_reg <= i_done_next;
            d_done_reg <= d_done_next;
        end
    end

    // Classify the cycle, then derive enables, squash, capture and flag updates.
    always_comb begin
        i_ok    = ~icache_read | icache_resp | i_done_reg;
        d_ok    = ~(dcache_read | dcache_write) | dcache_resp | d_done_reg;
        advance = i_ok & d_ok;

        cause = STALL_NONE;
        if (!advance) begin
            cause = STALL_MEM;
        end else if (br_taken) begin
            cause = STALL_FLUSH;
        end else if (stall_lw) begin
            cause = STALL_LOADUSE;
        end

        load_pc     = 1'b0;
        load_ifid   = 1'b0;
        load_idex   = 1'b0;
        load_exmem  = 1'b0;
        load_memwb  = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        ibuf_load   = 1'b0;
        ibuf_sel    = 1'b0;
        dbuf_load   = 1'b0;
        dbuf_sel    = 1'b0;
        icache_mask = 1'b0;
        dcache_mask = 1'b0;

        if (!rst) begin
            // A response is only parked when the pipe cannot consume it now.
            // A duplicate response while the flag is set is ignored.
            ibuf_load   = icache_resp & ~i_done_reg & ~advance;
            dbuf_load   = dcache_resp & ~d_done_reg & ~advance;
            ibuf_sel    = i_done_reg;
            icache_mask = i_done_reg;
            dbuf_sel    = d_done_reg;
            dcache_mask = d_done_reg;

            case (cause)
                STALL_MEM: begin
                    // Whole pipe frozen; EX/ID re-present their events later.
                end
                STALL_FLUSH: begin
                    {load_pc, load_ifid, load_idex, load_exmem, load_memwb} = 5'b11111;
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end
                STALL_LOADUSE: begin
                    {load_pc, load_ifid, load_idex, load_exmem, load_memwb} = 5'b00111;
                    bubble_idex = 1'b1;
                end
                default: begin
                    {load_pc, load_ifid, load_idex, load_exmem, load_memwb} = 5'b11111;
                end
            endcase
        end

        // An advance consumes any parked data. When the front end is held
        // for a load-use bubble, a parked instruction is dropped and refetched.
        i_done_next = i_done_reg;
        d_done_next = d_done_reg;
        if (advance) begin
            i_done_next = 1'b0;
            d_done_next = 1'b0;
        end else begin
            if (ibuf_load) i_done_next = 1'b1;
            if (dbuf_load) d_done_next = 1'b1;
        end

        cnt_inc[0] = (cause == STALL_MEM);
        cnt_inc[1] = (cause == STALL_LOADUSE);
        cnt_inc[2] = (cause == STALL_FLUSH);
    end

    // Counter 0 counts memory stall cycles.
    // Counter 1 counts load-use bubbles.
    // Counter 2 counts redirect flushes.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .clr   (cnt_clear),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cycles = cnt_val[0];
    assign bubble_count = cnt_val[1];
    assign flush_count  = cnt_val[2];

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller. It runs directed scenarios and
// a randomized run. The reference model describes the pipeline in terms of
// outstanding memory requests, parked responses and event priorities.
module tb_hazard_controller;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst, stall_lw, br_taken, icache_read, icache_resp;
    logic dcache_read, dcache_write, dcache_resp, cnt_clear;
    logic load_pc, load_ifid, load_idex, load_exmem, load_memwb;
    logic flush_ifid, bubble_idex, ibuf_load, ibuf_sel, dbuf_load, dbuf_sel;
    logic icache_mask, dcache_mask;
    logic [W-1:0] stall_cycles, bubble_count, flush_count;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    bit           m_ipark, m_dpark;
    logic [W-1:0] m_stall, m_bubble, m_flush;
    bit           m_frozen;
    logic [12:0]  exp_outs;
    logic [12:0]  outs;

    always #5 clk = ~clk;

    hazard_controller #(.CNT_W(W)) dut (
        .clk(clk), .rst(rst), .stall_lw(stall_lw), .br_taken(br_taken),
        .icache_read(icache_read), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_resp(dcache_resp), .cnt_clear(cnt_clear),
        .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
        .load_exmem(load_exmem), .load_memwb(load_memwb),
        .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
        .ibuf_load(ibuf_load), .ibuf_sel(ibuf_sel),
        .dbuf_load(dbuf_load), .dbuf_sel(dbuf_sel),
        .icache_mask(icache_mask), .dcache_mask(dcache_mask),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count),
        .flush_count(flush_count)
    );

    assign outs = {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
                   flush_ifid, bubble_idex, ibuf_load, ibuf_sel,
                   dbuf_load, dbuf_sel, icache_mask, dcache_mask};

    task automatic idle_inputs();
        stall_lw = 0; br_taken = 0; icache_read = 0; icache_resp = 0;
        dcache_read = 0; dcache_write = 0; dcache_resp = 0; cnt_clear = 0;
        rst = 0;
    endtask

    // Wait to mid-cycle and predict the outputs.
    // Prediction is from the model's view of outstanding requests.
    task automatic settle();
        bit i_waiting, d_waiting;
        bit [4:0] loads;
        bit fl, bb;
        @(negedge clk);
        i_waiting = icache_read && !icache_resp && !m_ipark;
        d_waiting = (dcache_read || dcache_write) && !dcache_resp && !m_dpark;
        m_frozen  = i_waiting || d_waiting;
        loads = 5'b11111; fl = 0; bb = 0;
        if (m_frozen)      loads = 5'b00000;
        else if (br_taken) begin fl = 1; bb = 1; end
        else if (stall_lw) begin loads = 5'b00111; bb = 1; end
        if (rst) exp_outs = '0;
        else exp_outs = {loads, fl, bb,
                         icache_resp && !m_ipark && m_frozen, m_ipark,
                         dcache_resp && !m_dpark && m_frozen, m_dpark,
                         m_ipark, m_dpark};
    endtask

    // Clock edge plus model update from the inputs held across it.
    task automatic tick();
        bit do_flush, do_bubble;
        do_flush  = !m_frozen && br_taken;
        do_bubble = !m_frozen && !br_taken && stall_lw;
        @(posedge clk);
        if (rst) begin
            m_ipark = 0; m_dpark = 0; m_stall = 0; m_bubble = 0; m_flush = 0;
        end else begin
            if (!m_frozen) begin
                m_ipark = 0; m_dpark = 0;
            end else begin
                if (icache_resp) m_ipark = 1;
                if (dcache_resp) m_dpark = 1;
            end
            if (cnt_clear) begin
                m_stall = 0; m_bubble = 0; m_flush = 0;
            end else begin
                if (m_frozen  && m_stall  != '1) m_stall++;
                if (do_bubble && m_bubble != '1) m_bubble++;
                if (do_flush  && m_flush  != '1) m_flush++;
            end
        end
        #1;
    endtask

    task automatic clear_counters();
        idle_inputs();
        cnt_clear = 1;
        settle();
        tick();
        cnt_clear = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; icache_read = 1; icache_resp = 1; dcache_read = 1;
        dcache_resp = 1; br_taken = 1; stall_lw = 1;
        settle(); tick();
        settle(); tick();
        settle();
        tests++;
        if (outs !== 13'b0) begin
            fails++; $display("FAIL reset_outs got=%b exp=%b", outs, 13'b0);
        end
        tests++;
        if ({stall_cycles, bubble_count, flush_count} !== '0) begin
            fails++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0",
                              stall_cycles, bubble_count, flush_count);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_imiss();
        clear_counters();
        icache_read = 1;
        for (int c = 0; c <= 4; c++) begin
            icache_resp = (c == 4);
            settle();
            tests++;
            if (outs !== exp_outs) begin
                fails++; $display("FAIL imiss_outs cyc=%0d got=%b exp=%b", c, outs, exp_outs);
            end
            tests++;
            if (load_pc !== (c == 4) || ibuf_load !== 1'b0) begin
                fails++; $display("FAIL imiss_enable cyc=%0d got load_pc=%b ibuf_load=%b exp %b/0",
                                  c, load_pc, ibuf_load, (c == 4));
            end
            tick();
        end
        idle_inputs();
        settle();
        tests++;
        if (stall_cycles !== W'(4)) begin
            fails++; $display("FAIL imiss_stall_cycles got=%0d exp=4", stall_cycles);
        end
        tick();
    endtask

    task automatic test_split();
        clear_counters();
        icache_read = 1; dcache_read = 1;
        for (int c = 0; c <= 6; c++) begin
            icache_resp = (c == 2);
            dcache_resp = (c == 6);
            settle();
            tests++;
            if (outs !== exp_outs) begin
                fails++; $display("FAIL split_outs cyc=%0d got=%b exp=%b", c, outs, exp_outs);
            end
            tests++;
            if (ibuf_load !== (c == 2) || ibuf_sel !== (c >= 3) ||
                icache_mask !== (c >= 3) || load_pc !== (c == 6)) begin
                fails++; $display("FAIL split_latch cyc=%0d got ibuf_load=%b ibuf_sel=%b mask=%b load_pc=%b",
                                  c, ibuf_load, ibuf_sel, icache_mask, load_pc);
            end
            tick();
        end
        idle_inputs();
        settle();
        tests++;
        if (ibuf_sel !== 1'b0 || stall_cycles !== W'(6)) begin
            fails++; $display("FAIL split_after got ibuf_sel=%b stall=%0d exp 0/6", ibuf_sel, stall_cycles);
        end
        tick();
    endtask

    task automatic test_loaduse();
        clear_counters();
        stall_lw = 1;
        for (int c = 0; c < 2; c++) begin
            settle();
            tests++;
            if (outs[12:6] !== 7'b0011101) begin
                fails++; $display("FAIL loaduse_ctrl cyc=%0d got=%b exp=0011101", c, outs[12:6]);
            end
            tick();
        end
        idle_inputs();
        settle();
        tests++;
        if (bubble_count !== W'(2)) begin
            fails++; $display("FAIL loaduse_count got=%0d exp=2", bubble_count);
        end
        tick();
    endtask

    task automatic test_branch_loaduse();
        clear_counters();
        stall_lw = 1; br_taken = 1;
        settle();
        tests++;
        if (outs[12:6] !== 7'b1111111) begin
            fails++; $display("FAIL br_lw_ctrl got=%b exp=1111111", outs[12:6]);
        end
        tick();
        idle_inputs();
        settle();
        tests++;
        if (flush_count !== W'(1) || bubble_count !== W'(0)) begin
            fails++; $display("FAIL br_lw_counts got flush=%0d bubble=%0d exp 1/0", flush_count, bubble_count);
        end
        tick();
    endtask

    task automatic test_branch_dmiss();
        clear_counters();
        dcache_read = 1; br_taken = 1;
        for (int c = 0; c <= 3; c++) begin
            dcache_resp = (c == 3);
            settle();
            tests++;
            if (flush_ifid !== (c == 3) || outs !== exp_outs) begin
                fails++; $display("FAIL br_dmiss cyc=%0d got=%b exp=%b flush exp=%b",
                                  c, outs, exp_outs, (c == 3));
            end
            tick();
        end
        idle_inputs();
        settle();
        tests++;
        if (flush_count !== W'(1) || stall_cycles !== W'(3)) begin
            fails++; $display("FAIL br_dmiss_counts got flush=%0d stall=%0d exp 1/3", flush_count, stall_cycles);
        end
        tick();
    endtask

    task automatic test_counter_edges();
        logic [W-1:0] all_ones;
        all_ones = '1;
        clear_counters();
        icache_read = 1;
        for (int c = 0; c < (1 << W) + 3; c++) begin
            settle(); tick();
        end
        settle();
        tests++;
        if (stall_cycles !== all_ones) begin
            fails++; $display("FAIL sat_hold got=%0d exp=%0d", stall_cycles, all_ones);
        end
        cnt_clear = 1;
        tick();
        cnt_clear = 0;
        settle();
        tests++;
        if (stall_cycles !== W'(0)) begin
            fails++; $display("FAIL clear_beats_inc got=%0d exp=0", stall_cycles);
        end
        tick();
        dcache_read = 1; icache_resp = 1;
        settle(); tick();
        icache_resp = 0;
        settle();
        tests++;
        if (ibuf_sel !== 1'b1 || stall_cycles !== W'(2)) begin
            fails++; $display("FAIL midstall_pre got ibuf_sel=%b stall=%0d exp 1/2", ibuf_sel, stall_cycles);
        end
        rst = 1; cnt_clear = 1;
        tick();
        rst = 0; cnt_clear = 0;
        settle();
        tests++;
        if (ibuf_sel !== 1'b0 || icache_mask !== 1'b0 || stall_cycles !== W'(0)) begin
            fails++; $display("FAIL midstall_rst got ibuf_sel=%b mask=%b stall=%0d exp 0/0/0",
                              ibuf_sel, icache_mask, stall_cycles);
        end
        tick();
        idle_inputs();
        settle(); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 63) == 0);
            cnt_clear    = ($urandom_range(0, 47) == 0);
            stall_lw     = ($urandom_range(0, 3) == 0);
            br_taken     = ($urandom_range(0, 4) == 0);
            icache_read  = ($urandom_range(0, 1) == 0);
            icache_resp  = ($urandom_range(0, 2) == 0);
            dcache_read  = ($urandom_range(0, 3) == 0);
            dcache_write = ($urandom_range(0, 4) == 0);
            dcache_resp  = ($urandom_range(0, 2) == 0);
            settle();
            tests++;
            if (outs !== exp_outs) begin
                fails++; $display("FAIL rand_outs cyc=%0d got=%b exp=%b", c, outs, exp_outs);
            end
            tests++;
            if (stall_cycles !== m_stall || bubble_count !== m_bubble || flush_count !== m_flush) begin
                fails++; $display("FAIL rand_counts cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c,
                                  stall_cycles, bubble_count, flush_count, m_stall, m_bubble, m_flush);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        m_ipark = 0; m_dpark = 0; m_stall = 0; m_bubble = 0; m_flush = 0;
        m_frozen = 0; exp_outs = '0;
        idle_inputs();
        rst = 1;
        #1;
        test_reset();
        test_imiss();
        test_split();
        test_loaduse();
        test_branch_loaduse();
        test_branch_dmiss();
        test_counter_edges();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
